audio_sample_buffer: RTL and testbench
======================================

# audio_sample_buffer

Parametrised stereo sample buffer between the audio codec read/write handshake and the DAC path. Each accepted input sample pair is stored in a circular memory. Each output request is served according to a run-time mode: passthrough, fixed delay, reverse playback (LIFO), or feedback echo. Occupancy and overflow/underflow status are exported for the LED/debug logic.

## Interface
- AUDIO_DATA_WIDTH, 24, signed sample width per channel
- ADDR_WIDTH, 7, memory depth DEPTH = 2^ADDR_WIDTH sample pairs per channel
- ECHO_SHIFT, 1, arithmetic right shift applied to the echo feedback tap
- clk  in  1  system clock; one clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- mode  in  2  00 PASS, 01 DELAY, 10 REVERSE, 11 ECHO
- delay_len  in  ADDR_WIDTH  tap distance in samples for DELAY and ECHO; 0 selects the newest stored sample
- read_ready  in  1  codec has an input sample pair available
- write_ready  in  1  codec can accept an output sample pair
- readdata_left, readdata_right  in  AUDIO_DATA_WIDTH  signed input samples
- read  out  1  combinational: read_ready
- write  out  1  combinational: write_ready & ~read_ready
- writedata_left, writedata_right  out  AUDIO_DATA_WIDTH  registered signed output samples
- fill_count  out  ADDR_WIDTH+1  registered occupancy, range 0..DEPTH
- overflow  out  1  registered one-cycle pulse: push refused (REVERSE full)
- underflow  out  1  registered one-cycle pulse: pop refused (REVERSE empty)

## Operation
- Read event (RE) = read_ready. Write event (WE) = write_ready & ~read_ready. Read has priority, and at most one event is processed per cycle.
- State: wp (ADDR_WIDTH, wraps modulo DEPTH), cnt (ADDR_WIDTH+1), last_l/last_r, mode_q. fill_count = cnt. Memory is not reset.
- Tap address = wp − 1 − delay_len, modulo DEPTH. The tap is valid iff cnt > delay_len; an invalid tap reads as 0.
- PASS
  - RE: last_* ← readdata_*. Memory, wp and cnt are untouched (cnt stays 0).
  - WE: writedata_* ← last_*.
- DELAY
  - RE: mem[wp] ← readdata_*; wp++; cnt saturates at DEPTH.
  - WE: writedata_* ← tap (0 if invalid).
- REVERSE
  - RE: if cnt < DEPTH, then mem[wp] ← readdata_*, wp++, cnt++. Otherwise the sample is dropped and overflow pulses.
  - WE: if cnt > 0, then writedata_* ← mem[wp−1], wp−−, cnt−−. Otherwise writedata_* ← 0 and underflow pulses.
- ECHO
  - RE: y = readdata + (tap >>> ECHO_SHIFT), computed in AUDIO_DATA_WIDTH+1 bits and saturated to [−2^(W−1), 2^(W−1)−1]. mem[wp] ← y; last_* ← y; wp++; cnt saturates at DEPTH.
  - WE: writedata_* ← last_*.
- Left and right are processed identically and independently, with shared wp and cnt.
- Mode change: at the first edge where mode ≠ mode_q:
  - mode_q ← mode; wp ← 0; cnt ← 0; last_* ← 0.
  - Any RE/WE in that cycle is ignored; the read/write strobes still follow the handshake rule.
  - writedata_* holds its value. Flags are not pulsed.
- delay_len is used combinationally and takes effect on the next event, with no flush.

## Timing
- Reset (async assert, sync deassert by the board reset logic): writedata_* = 0, fill_count = 0, overflow = underflow = 0, wp = 0, last_* = 0, mode_q = 00.
- read and write have zero latency from read_ready and write_ready.
- writedata_* and fill_count update on the same posedge where the event is sampled; values are visible the following cycle.
- overflow and underflow are high for exactly the one cycle after the refusing edge.
- Reset asserted mid-operation aborts immediately. Memory contents are kept but unreachable, because cnt = 0.
- Wrap-around: wp DEPTH−1 → 0 on push; 0 → DEPTH−1 on pop.

## Test plan
- Reset: assert reset mid-stream → all outputs 0 within the same cycle; then one RE and one WE in DELAY with delay_len 0 → writedata equals the pushed sample.
- DELAY: push 1,2,3…,10 with delay_len = 3, interleaving a WE after each RE.
  - First three WEs output 0.
  - Fourth and later WEs output sample n−3.
  - fill_count reads 10.
- REVERSE full/empty (ADDR_WIDTH 3): push 1..9 → overflow pulses once, and fill_count = 8. Then 9 WEs → outputs 8,7,…,1, then 0 with an underflow pulse.
- ECHO saturation: delay_len 0, ECHO_SHIFT 1, push 0x7FFFFF twice → second stored and output value is 0x7FFFFF, not wrapped. Repeat with 0x800000 → clamps to 0x800000.
- Simultaneous read_ready and write_ready: write = 0, only the push occurs, writedata is unchanged. Then deassert read_ready → the WE occurs.
- Mode switch DELAY → REVERSE after 5 pushes: fill_count → 0, writedata holds. The next WE underflows with output 0.

Source files
------------

// File: rtl/audio_sample_buffer.sv
// Stereo circular sample buffer between the codec handshake and the DAC path.
// Output requests are served as passthrough, fixed delay, LIFO reverse or feedback echo.
module audio_sample_buffer #(
  parameter int AUDIO_DATA_WIDTH = 24,
  parameter int ADDR_WIDTH       = 7,
  parameter int ECHO_SHIFT       = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [1:0]                         mode,
  input  logic [ADDR_WIDTH-1:0]              delay_len,
  input  logic                               read_ready,
  input  logic                               write_ready,
  input  logic signed [AUDIO_DATA_WIDTH-1:0] readdata_left,
  input  logic signed [AUDIO_DATA_WIDTH-1:0] readdata_right,
  output logic                               read,
  output logic                               write,
  output logic signed [AUDIO_DATA_WIDTH-1:0] writedata_left,
  output logic signed [AUDIO_DATA_WIDTH-1:0] writedata_right,
  output logic [ADDR_WIDTH:0]                fill_count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int W     = AUDIO_DATA_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0]    M_PASS    = 2'b00;
  localparam logic [1:0]    M_DELAY   = 2'b01;
  localparam logic [1:0]    M_REVERSE = 2'b10;
  localparam logic [1:0]    M_ECHO    = 2'b11;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  logic signed [W-1:0] mem_l [DEPTH];
  logic signed [W-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] wp, wp_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [1:0]            mode_q, mode_n;
  logic signed [W-1:0]   last_l, last_r, last_l_n, last_r_n;
  logic signed [W-1:0]   wd_l_n, wd_r_n;
  logic                  ovf_n, unf_n;

  logic                  rd_ev, wr_ev, mode_chg;
  logic [ADDR_WIDTH-1:0] top_addr, tap_addr;
  logic                  tap_vld;
  logic signed [W-1:0]   tap_l, tap_r, echo_l, echo_r;
  logic                  push;
  logic signed [W-1:0]   push_l, push_r;

  // Echo feedback: widen by one bit, add the attenuated tap, clamp to the sample range.
  function automatic logic signed [W-1:0] sat_echo(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] tap);
    logic signed [W-1:0] sh;
    logic [W:0]          sum;
    sh  = tap >>> ECHO_SHIFT;
    sum = {x[W-1], x} + {sh[W-1], sh};
    if (sum[W] != sum[W-1])
      sat_echo = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_echo = sum[W-1:0];
  endfunction

  assign rd_ev      = read_ready;
  assign wr_ev      = write_ready & ~read_ready;
  assign read       = rd_ev;
  assign write      = wr_ev;
  assign mode_chg   = (mode != mode_q);
  assign fill_count = cnt;

  assign top_addr = wp - ADDR_WIDTH'(1);
  assign tap_addr = wp - ADDR_WIDTH'(1) - delay_len;
  assign tap_vld  = (cnt > {1'b0, delay_len});
  assign tap_l    = tap_vld ? mem_l[tap_addr] : '0;
  assign tap_r    = tap_vld ? mem_r[tap_addr] : '0;
  assign echo_l   = sat_echo(readdata_left, tap_l);
  assign echo_r   = sat_echo(readdata_right, tap_r);

  always_comb begin
    wp_n     = wp;
    cnt_n    = cnt;
    mode_n   = mode_q;
    last_l_n = last_l;
    last_r_n = last_r;
    wd_l_n   = writedata_left;
    wd_r_n   = writedata_right;
    push     = 1'b0;
    push_l   = readdata_left;
    push_r   = readdata_right;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    if (mode_chg) begin
      // A mode switch restarts the buffer; the event of this cycle is discarded.
      mode_n   = mode;
      wp_n     = '0;
      cnt_n    = '0;
      last_l_n = '0;
      last_r_n = '0;
    end else if (rd_ev) begin
      case (mode_q)
        M_PASS: begin
          last_l_n = readdata_left;
          last_r_n = readdata_right;
        end
        M_DELAY: begin
          push  = 1'b1;
          wp_n  = wp + ADDR_WIDTH'(1);
          cnt_n = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);
        end
        M_REVERSE: begin
          if (cnt != CNT_FULL) begin
            push  = 1'b1;
            wp_n  = wp + ADDR_WIDTH'(1);
            cnt_n = cnt + CW'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end
        default: begin
          push     = 1'b1;
          push_l   = echo_l;
          push_r   = echo_r;
          last_l_n = echo_l;
          last_r_n = echo_r;
          wp_n     = wp + ADDR_WIDTH'(1);
          cnt_n    = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);
        end
      endcase
    end else if (wr_ev) begin
      case (mode_q)
        M_DELAY: begin
          wd_l_n = tap_l;
          wd_r_n = tap_r;
        end
        M_REVERSE: begin
          if (cnt != '0) begin
            wd_l_n = mem_l[top_addr];
            wd_r_n = mem_r[top_addr];
            wp_n   = top_addr;
            cnt_n  = cnt - CW'(1);
          end else begin
            wd_l_n = '0;
            wd_r_n = '0;
            unf_n  = 1'b1;
          end
        end
        default: begin
          wd_l_n = last_l;
          wd_r_n = last_r;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp              <= '0;
      cnt             <= '0;
      mode_q          <= M_PASS;
      last_l          <= '0;
      last_r          <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      wp              <= wp_n;
      cnt             <= cnt_n;
      mode_q          <= mode_n;
      last_l          <= last_l_n;
      last_r          <= last_r_n;
      writedata_left  <= wd_l_n;
      writedata_right <= wd_r_n;
      overflow        <= ovf_n;
      underflow       <= unf_n;
    end
  end

  // Sample storage carries no reset; stale contents are masked by cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wp] <= push_l;
      mem_r[wp] <= push_r;
    end
  end

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Bench for audio_sample_buffer: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_audio_sample_buffer;

  localparam int W     = 24;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            mode;
  logic [AW-1:0]         delay_len;
  logic                  read_ready, write_ready;
  logic signed [W-1:0]   readdata_left, readdata_right;
  logic                  read, write;
  logic signed [W-1:0]   writedata_left, writedata_right;
  logic [AW:0]           fill_count;
  logic                  overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic signed [W-1:0] q_l[$], q_r[$];
  logic signed [W-1:0] m_last_l, m_last_r, m_wd_l, m_wd_r;
  logic [1:0]          m_mode;
  logic                m_ovf, m_unf;

  audio_sample_buffer #(
    .AUDIO_DATA_WIDTH(W),
    .ADDR_WIDTH      (AW),
    .ECHO_SHIFT      (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .delay_len      (delay_len),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .read           (read),
    .write          (write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .fill_count     (fill_count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [W-1:0] echo_y(input logic signed [W-1:0] x,
                                                 input logic signed [W-1:0] tap);
    int s;
    s = int'(x) + (int'(tap) >>> 1);
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
    return s[W-1:0];
  endfunction

  task automatic model_reset();
    q_l.delete(); q_r.delete();
    m_last_l = '0; m_last_r = '0;
    m_wd_l = '0; m_wd_r = '0;
    m_mode = 2'b00;
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic rr, input logic wr,
                            input logic signed [W-1:0] dl, input logic signed [W-1:0] dr);
    int d;
    logic signed [W-1:0] tl, tr, yl, yr;
    d = int'(delay_len);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    tl = (q_l.size() > d) ? q_l[q_l.size()-1-d] : '0;
    tr = (q_r.size() > d) ? q_r[q_r.size()-1-d] : '0;
    if (mode != m_mode) begin
      m_mode = mode;
      q_l.delete(); q_r.delete();
      m_last_l = '0; m_last_r = '0;
    end else if (rr) begin
      case (m_mode)
        2'b00: begin m_last_l = dl; m_last_r = dr; end
        2'b01: begin
          q_l.push_back(dl); q_r.push_back(dr);
          if (q_l.size() > DEPTH) begin void'(q_l.pop_front()); void'(q_r.pop_front()); end
        end
        2'b10: begin
          if (q_l.size() < DEPTH) begin q_l.push_back(dl); q_r.push_back(dr); end
          else m_ovf = 1'b1;
        end
        default: begin
          yl = echo_y(dl, tl); yr = echo_y(dr, tr);
          q_l.push_back(yl); q_r.push_back(yr);
          if (q_l.size() > DEPTH) begin void'(q_l.pop_front()); void'(q_r.pop_front()); end
          m_last_l = yl; m_last_r = yr;
        end
      endcase
    end else if (wr) begin
      case (m_mode)
        2'b01: begin m_wd_l = tl; m_wd_r = tr; end
        2'b10: begin
          if (q_l.size() > 0) begin m_wd_l = q_l.pop_back(); m_wd_r = q_r.pop_back(); end
          else begin m_wd_l = '0; m_wd_r = '0; m_unf = 1'b1; end
        end
        default: begin m_wd_l = m_last_l; m_wd_r = m_last_r; end
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wd_l"}, 32'(writedata_left), 32'(m_wd_l));
    chk({tag, ".wd_r"}, 32'(writedata_right), 32'(m_wd_r));
    chk({tag, ".fill"}, 32'(fill_count), 32'(q_l.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input logic rr, input logic wr,
                      input logic signed [W-1:0] dl, input logic signed [W-1:0] dr);
    @(negedge clk);
    read_ready = rr; write_ready = wr;
    readdata_left = dl; readdata_right = dr;
    #1;
    chk({tag, ".read"}, 32'(read), 32'(rr));
    chk({tag, ".write"}, 32'(write), 32'(wr & ~rr));
    @(posedge clk);
    model_step(rr, wr, dl, dr);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic signed [W-1:0] a, b;
    reset = 1'b1; mode = 2'b00; delay_len = '0;
    read_ready = 1'b0; write_ready = 1'b0;
    readdata_left = '0; readdata_right = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("rst");
    reset = 1'b0;

    // DELAY, tap distance 3
    mode = 2'b01; delay_len = 3'd3;
    step("dly_sw", 1'b0, 1'b0, '0, '0);
    for (int n = 1; n <= 10; n++) begin
      step("dly_push", 1'b1, 1'b0, W'(n), -W'(n));
      step("dly_pop", 1'b0, 1'b1, '0, '0);
    end

    // REVERSE full / empty
    mode = 2'b10;
    step("rev_sw", 1'b0, 1'b0, '0, '0);
    for (int n = 1; n <= 9; n++) step("rev_push", 1'b1, 1'b0, W'(n), W'(100 + n));
    for (int n = 1; n <= 9; n++) step("rev_pop", 1'b0, 1'b1, '0, '0);
    step("rev_idle", 1'b0, 1'b0, '0, '0);

    // ECHO saturation
    mode = 2'b11; delay_len = '0;
    step("echo_sw", 1'b0, 1'b0, '0, '0);
    step("echo_pmax", 1'b1, 1'b0, 24'h7FFFFF, 24'h7FFFFF);
    step("echo_pmax", 1'b1, 1'b0, 24'h7FFFFF, 24'h7FFFFF);
    step("echo_omax", 1'b0, 1'b1, '0, '0);
    chk("echo_max_val", 32'(writedata_left), 32'h007FFFFF);
    step("echo_pmin", 1'b1, 1'b0, 24'h800000, 24'h800000);
    step("echo_pmin", 1'b1, 1'b0, 24'h800000, 24'h800000);
    step("echo_omin", 1'b0, 1'b1, '0, '0);
    chk("echo_min_val", 32'(writedata_left), 32'hFF800000);

    // Simultaneous handshakes, then mode switch DELAY -> REVERSE
    mode = 2'b01;
    step("sim_sw", 1'b0, 1'b0, '0, '0);
    step("sim_push", 1'b1, 1'b0, 24'sd5, 24'sd55);
    step("sim_pop", 1'b0, 1'b1, '0, '0);
    step("sim_both", 1'b1, 1'b1, 24'sd6, 24'sd66);
    step("sim_pop2", 1'b0, 1'b1, '0, '0);
    for (int n = 0; n < 5; n++) step("msw_push", 1'b1, 1'b0, W'(200 + n), W'(300 + n));
    mode = 2'b10;
    step("msw_sw", 1'b0, 1'b1, '0, '0);
    step("msw_unf", 1'b0, 1'b1, '0, '0);

    // PASS
    mode = 2'b00;
    step("pass_sw", 1'b0, 1'b0, '0, '0);
    step("pass_rd", 1'b1, 1'b0, -24'sd77, 24'sd88);
    step("pass_wr", 1'b0, 1'b1, '0, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) delay_len = AW'($urandom_range(DEPTH - 1));
      a = W'($urandom); b = W'($urandom);
      if ($urandom_range(5) == 0) a = ($urandom_range(1) == 1) ? 24'h7FFFF0 : 24'h800010;
      step("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), a, b);
    end

    // Mid-stream reset, then DELAY with tap 0
    mode = 2'b01; delay_len = '0;
    step("pre_sw", 1'b0, 1'b0, '0, '0);
    step("pre_push", 1'b1, 1'b0, 24'sd9, 24'sd10);
    step("pre_pop", 1'b0, 1'b1, '0, '0);
    @(negedge clk);
    read_ready = 1'b0; write_ready = 1'b0; mode = 2'b00;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    @(negedge clk);
    reset = 1'b0;
    mode = 2'b01;
    step("post_sw", 1'b0, 1'b0, '0, '0);
    step("post_push", 1'b1, 1'b0, 24'sd1234, -24'sd4321);
    step("post_pop", 1'b0, 1'b1, '0, '0);
    chk("post_val", 32'(writedata_left), 32'd1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
